// File: rtl/regfile_multiport_pkg.sv
// regfile_pkg: shared clear-FSM state type and default geometry for the register file
package regfile_pkg;
  typedef enum logic {RF_IDLE, RF_CLEAR} rf_state_t;
  localparam int RF_WIDTH = 4;
  localparam int RF_DEPTH = 8;
endpackage

// File: rtl/regfile_multiport_read_port.sv
// rf_read_port: one combinational read port with hardwired-zero and write-bypass selection
module rf_read_port #(
  parameter int WIDTH = 4,
  parameter int AW = 3,
  parameter int BYPASS = 1,
  parameter int ZERO_REG = 0
) (
  input  logic             idle,
  input  logic [AW-1:0]    raddr,
  input  logic [WIDTH-1:0] word,
  input  logic             we0,
  input  logic [AW-1:0]    waddr0,
  input  logic [WIDTH-1:0] wdata0,
  input  logic             we1,
  input  logic [AW-1:0]    waddr1,
  input  logic [WIDTH-1:0] wdata1,
  output logic [WIDTH-1:0] rdata
);
  logic hit0, hit1;
  always_comb begin
    hit1 = BYPASS != 0 && idle && we1 && waddr1 == raddr;
    hit0 = BYPASS != 0 && idle && we0 && waddr0 == raddr;
    rdata = (ZERO_REG != 0 && raddr == '0) ? '0 : hit1 ? wdata1 : hit0 ? wdata0 : word;
  end
endmodule

// File: rtl/regfile_multiport.sv
// regfile_multiport: DEPTH x WIDTH register file, 2 write ports, NUM_RD read ports, clear sweep
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH,
  parameter int DEPTH = RF_DEPTH,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1,
  parameter int ZERO_REG = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         we0,
  input  logic [$clog2(DEPTH)-1:0]     waddr0,
  input  logic [WIDTH-1:0]             wdata0,
  input  logic                         we1,
  input  logic [$clog2(DEPTH)-1:0]     waddr1,
  input  logic [WIDTH-1:0]             wdata1,
  input  logic [NUM_RD*$clog2(DEPTH)-1:0] raddr,
  output logic [NUM_RD*WIDTH-1:0]      rdata,
  input  logic                         clear_req,
  output logic                         busy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  logic [WIDTH-1:0] mem [DEPTH];
  rf_state_t state, state_nx;
  logic [AW-1:0] idx;
  logic idle, wr0, wr1;
  always_comb begin
    idle = state == RF_IDLE;
    busy = state == RF_CLEAR;
    wr0 = idle && we0 && !(ZERO_REG != 0 && waddr0 == '0);
    wr1 = idle && we1 && !(ZERO_REG != 0 && waddr1 == '0);
    state_nx = idle ? (clear_req ? RF_CLEAR : RF_IDLE) : (idx == LAST ? RF_IDLE : RF_CLEAR);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RF_IDLE;
      idx <= '0;
    end else begin
      state <= state_nx;
      idx <= (busy && idx != LAST) ? idx + 1'b1 : '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (busy) begin
      mem[idx] <= '0;
    end else begin
      if (wr0) mem[waddr0] <= wdata0;
      if (wr1) mem[waddr1] <= wdata1;
    end
  end
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    rf_read_port #(.WIDTH(WIDTH), .AW(AW), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)) u_rd (
      .idle(idle),
      .raddr(raddr[i*AW +: AW]),
      .word(mem[raddr[i*AW +: AW]]),
      .we0(we0),
      .waddr0(waddr0),
      .wdata0(wdata0),
      .we1(we1),
      .waddr1(waddr1),
      .wdata1(wdata1),
      .rdata(rdata[i*WIDTH +: WIDTH])
    );
  end
endmodule

// File: tb/tb_regfile_multiport.sv
// tb_regfile_multiport: vector table plus scoreboard checks over bypass, no-bypass and zero-reg variants
module tb_regfile_multiport;
  logic clk = 0, rst_n = 0, we0 = 0, we1 = 0, clear_req = 0;
  logic [2:0] waddr0 = 0, waddr1 = 0;
  logic [3:0] wdata0 = 0, wdata1 = 0;
  logic [5:0] raddr = 0;
  logic [7:0] rd, rd_nb, rd_z;
  logic busy, busy_nb, busy_z;
  int n_chk = 0, n_pass = 0;
  logic [3:0] m [8];
  logic [3:0] mz [8];
  typedef struct packed {
    logic we0; logic [2:0] a0; logic [3:0] d0;
    logic we1; logic [2:0] a1; logic [3:0] d1;
    logic [2:0] ra; logic [3:0] eb, en, ez;
  } vec_t;
  typedef struct packed {logic [2:0] a; logic [3:0] e, ez;} exp_t;
  vec_t vt [8];
  exp_t q [$];
  exp_t e;
  always #5 clk = ~clk;
  regfile_multiport dut (.clk(clk), .rst_n(rst_n), .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1), .raddr(raddr), .rdata(rd), .clear_req(clear_req), .busy(busy));
  regfile_multiport #(.BYPASS(0)) dut_nb (.clk(clk), .rst_n(rst_n), .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1), .raddr(raddr), .rdata(rd_nb), .clear_req(clear_req), .busy(busy_nb));
  regfile_multiport #(.ZERO_REG(1)) dut_z (.clk(clk), .rst_n(rst_n), .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1), .raddr(raddr), .rdata(rd_z), .clear_req(clear_req), .busy(busy_z));
  task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask
  task automatic fill(input logic [3:0] base, input logic inc);
    for (int a = 0; a < 8; a++) begin
      @(negedge clk);
      we0 = 1; waddr0 = 3'(a); wdata0 = inc ? base + 4'(a) : base;
      m[a] = wdata0;
      mz[a] = a == 0 ? 4'h0 : wdata0;
    end
    @(negedge clk);
    we0 = 0;
  endtask
  task automatic check_all_zero(input string nm);
    for (int a = 0; a < 8; a++) begin
      raddr = {3'(a), 3'(a)};
      #1;
      check({nm, "_rd"}, rd[3:0], 4'h0);
      check({nm, "_rd_p1"}, rd[7:4], 4'h0);
      check({nm, "_nb"}, rd_nb[3:0], 4'h0);
      check({nm, "_z"}, rd_z[3:0], 4'h0);
    end
  endtask
  initial begin
    int cnt;
    for (int a = 0; a < 8; a++) begin m[a] = 0; mz[a] = 0; end
    vt[0] = '{1'b1, 3'd3, 4'hA, 1'b0, 3'd0, 4'h0, 3'd3, 4'hA, 4'h0, 4'hA};
    vt[1] = '{1'b0, 3'd0, 4'h0, 1'b0, 3'd0, 4'h0, 3'd3, 4'hA, 4'hA, 4'hA};
    vt[2] = '{1'b1, 3'd5, 4'h1, 1'b1, 3'd5, 4'h2, 3'd5, 4'h2, 4'h0, 4'h2};
    vt[3] = '{1'b1, 3'd0, 4'hF, 1'b0, 3'd0, 4'h0, 3'd0, 4'hF, 4'h0, 4'h0};
    vt[4] = '{1'b1, 3'd6, 4'h4, 1'b1, 3'd7, 4'h9, 3'd6, 4'h4, 4'h0, 4'h4};
    vt[5] = '{1'b1, 3'd7, 4'hB, 1'b1, 3'd7, 4'hC, 3'd7, 4'hC, 4'h9, 4'hC};
    vt[6] = '{1'b1, 3'd1, 4'h3, 1'b0, 3'd0, 4'h0, 3'd3, 4'hA, 4'hA, 4'hA};
    vt[7] = '{1'b0, 3'd0, 4'h0, 1'b0, 3'd0, 4'h0, 3'd1, 4'h3, 4'h3, 4'h3};
    // reset state
    repeat (2) @(negedge clk);
    rst_n = 1;
    check_all_zero("reset");
    check("reset_busy", {3'b0, busy}, 4'h0);
    // table-driven writes with same-cycle and post-edge reads
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      {we0, waddr0, wdata0} = {vt[i].we0, vt[i].a0, vt[i].d0};
      {we1, waddr1, wdata1} = {vt[i].we1, vt[i].a1, vt[i].d1};
      raddr = {vt[i].ra, vt[i].ra};
      #1;
      check($sformatf("v%0d_byp", i), rd[3:0], vt[i].eb);
      check($sformatf("v%0d_byp_p1", i), rd[7:4], vt[i].eb);
      check($sformatf("v%0d_nobyp", i), rd_nb[3:0], vt[i].en);
      check($sformatf("v%0d_zero", i), rd_z[3:0], vt[i].ez);
      if (vt[i].we0) begin m[vt[i].a0] = vt[i].d0; if (vt[i].a0 != 0) mz[vt[i].a0] = vt[i].d0; end
      if (vt[i].we1) begin m[vt[i].a1] = vt[i].d1; if (vt[i].a1 != 0) mz[vt[i].a1] = vt[i].d1; end
      q.push_back('{vt[i].ra, m[vt[i].ra], mz[vt[i].ra]});
      @(posedge clk);
      #1;
      we0 = 0; we1 = 0;
      e = q.pop_front();
      raddr = {e.a, e.a};
      #1;
      check($sformatf("v%0d_post", i), rd[7:4], e.e);
      check($sformatf("v%0d_post_nb", i), rd_nb[7:4], e.e);
      check($sformatf("v%0d_post_z", i), rd_z[7:4], e.ez);
    end
    // clear sweep: write in request cycle commits, sweep-time writes and requests ignored
    fill(4'h7, 1'b0);
    @(negedge clk);
    clear_req = 1; we1 = 1; waddr1 = 3'd4; wdata1 = 4'hE;
    @(negedge clk);
    clear_req = 0; we1 = 0;
    we0 = 1; waddr0 = 3'd2; wdata0 = 4'h5; raddr = {3'd4, 3'd2};
    #1;
    check("sweep_no_bypass", rd[3:0], 4'h7);
    check("req_cycle_write", rd[7:4], 4'hE);
    cnt = 0;
    for (int i = 0; i < 20 && busy; i++) begin
      cnt++;
      clear_req = i == 4;
      @(negedge clk);
    end
    we0 = 0; clear_req = 0;
    check("busy_cycles", 4'(cnt), 4'h8);
    check("busy_after", {3'b0, busy}, 4'h0);
    check_all_zero("cleared");
    @(negedge clk);
    check("no_restart", {3'b0, busy}, 4'h0);
    // reset mid-sweep
    fill(4'h1, 1'b1);
    @(negedge clk);
    clear_req = 1;
    @(negedge clk);
    clear_req = 0;
    repeat (3) @(negedge clk);
    raddr = {3'd7, 3'd5};
    #1;
    check("mid_sweep_e5", rd[3:0], 4'h6);
    check("mid_sweep_e7", rd[7:4], 4'h8);
    check("mid_sweep_busy", {3'b0, busy}, 4'h1);
    #1;
    rst_n = 0;
    #1;
    check("rst_busy", {3'b0, busy}, 4'h0);
    check("rst_busy_nb", {3'b0, busy_nb}, 4'h0);
    check("rst_busy_z", {3'b0, busy_z}, 4'h0);
    check_all_zero("rst_mid");
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("post_rst_busy", {3'b0, busy}, 4'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
